// File: rtl/hella_cache_pkg.sv
// Shared constants and entry-state encoding for the HellaCache master engine.
package hella_cache_pkg;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd2;
  localparam logic [2:0] MT_D  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;
  localparam logic [2:0] MT_WU = 3'd6;

  localparam int unsigned RETRY_BITS = 4;

  typedef enum logic [2:0] {
    ENT_FREE   = 3'd0,
    ENT_PEND   = 3'd1,
    ENT_ISSUED = 3'd2,
    ENT_WDONE  = 3'd3,
    ENT_ERR    = 3'd4
  } entry_state_e;

endpackage

// File: rtl/hella_cache_tag_table.sv
// Tracking table: per-tag command storage, state, retry counters and
// lowest-index selection of free / pending / write-done / error entries.
module hella_cache_tag_table
  import hella_cache_pkg::*;
#(
  parameter int unsigned NUM_ADDR_BITS   = 40,
  parameter int unsigned NUM_DATA_BITS   = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_RETRY       = 3,
  localparam int unsigned IW = $clog2(MAX_OUTSTANDING),
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alloc_i,
  input  logic [4:0]                 alloc_cmd_i,
  input  logic [2:0]                 alloc_typ_i,
  input  logic [NUM_ADDR_BITS-1:0]   alloc_addr_i,
  input  logic [NUM_DATA_BITS-1:0]   alloc_data_i,
  input  logic [NUM_DATA_BITS/8-1:0] alloc_mask_i,
  output logic                       free_any_o,
  output logic [IW-1:0]              free_idx_o,
  output logic                       pend_any_o,
  output logic [IW-1:0]              pend_idx_o,
  output logic [4:0]                 pend_cmd_o,
  output logic [2:0]                 pend_typ_o,
  output logic [NUM_ADDR_BITS-1:0]   pend_addr_o,
  input  logic                       fire_i,
  input  logic [IW-1:0]              s1_idx_i,
  output logic [NUM_DATA_BITS-1:0]   s1_data_o,
  output logic [NUM_DATA_BITS/8-1:0] s1_mask_o,
  input  logic                       s2_valid_i,
  input  logic [IW-1:0]              s2_idx_i,
  input  logic                       s2_nack_i,
  output logic                       s2_nack_live_o,
  output logic                       s2_exhaust_o,
  input  logic                       exhaust_report_i,
  input  logic [IW-1:0]              rsp_idx_i,
  output logic                       rsp_issued_rd_o,
  input  logic                       rsp_done_i,
  input  logic                       rel_valid_i,
  input  logic [IW-1:0]              rel_idx_i,
  output logic                       err_any_o,
  output logic [IW-1:0]              err_idx_o,
  output logic                       wdone_any_o,
  output logic [IW-1:0]              wdone_idx_o,
  output logic [CW-1:0]              outstanding_o
);

  entry_state_e                state_q [MAX_OUTSTANDING];
  entry_state_e                state_d [MAX_OUTSTANDING];
  logic [RETRY_BITS-1:0]       retry_q [MAX_OUTSTANDING];
  logic [RETRY_BITS-1:0]       retry_d [MAX_OUTSTANDING];
  logic [4:0]                  cmd_q   [MAX_OUTSTANDING];
  logic [2:0]                  typ_q   [MAX_OUTSTANDING];
  logic [NUM_ADDR_BITS-1:0]    addr_q  [MAX_OUTSTANDING];
  logic [NUM_DATA_BITS-1:0]    data_q  [MAX_OUTSTANDING];
  logic [NUM_DATA_BITS/8-1:0]  mask_q  [MAX_OUTSTANDING];

  logic                        s2_live;
  logic [RETRY_BITS-1:0]       retry_inc;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    free_any_o  = 1'b0;
    free_idx_o  = '0;
    pend_any_o  = 1'b0;
    pend_idx_o  = '0;
    err_any_o   = 1'b0;
    err_idx_o   = '0;
    wdone_any_o = 1'b0;
    wdone_idx_o = '0;
    for (int unsigned i = MAX_OUTSTANDING; i > 0; i--) begin
      if (state_q[i-1] == ENT_FREE) begin
        free_any_o = 1'b1;
        free_idx_o = IW'(i - 1);
      end
      if (state_q[i-1] == ENT_PEND) begin
        pend_any_o = 1'b1;
        pend_idx_o = IW'(i - 1);
      end
      if (state_q[i-1] == ENT_ERR) begin
        err_any_o = 1'b1;
        err_idx_o = IW'(i - 1);
      end
      if (state_q[i-1] == ENT_WDONE) begin
        wdone_any_o = 1'b1;
        wdone_idx_o = IW'(i - 1);
      end
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (state_q[i] != ENT_FREE) outstanding_o = outstanding_o + CW'(1);
    end
  end

  assign pend_cmd_o  = cmd_q[pend_idx_o];
  assign pend_typ_o  = typ_q[pend_idx_o];
  assign pend_addr_o = addr_q[pend_idx_o];
  assign s1_data_o   = data_q[s1_idx_i];
  assign s1_mask_o   = mask_q[s1_idx_i];

  // A stale s2 slot (entry already answered and possibly reused) is ignored.
  assign s2_live         = s2_valid_i && (state_q[s2_idx_i] == ENT_ISSUED);
  assign retry_inc       = retry_q[s2_idx_i] + RETRY_BITS'(1);
  assign s2_nack_live_o  = s2_live && s2_nack_i;
  assign s2_exhaust_o    = s2_nack_live_o && (retry_inc == RETRY_BITS'(MAX_RETRY));
  assign rsp_issued_rd_o = (state_q[rsp_idx_i] == ENT_ISSUED) && (cmd_q[rsp_idx_i] != M_XWR);

  always_comb begin
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      state_d[i] = state_q[i];
      retry_d[i] = retry_q[i];
      if (alloc_i && free_idx_o == IW'(i)) begin
        state_d[i] = ENT_PEND;
        retry_d[i] = '0;
      end
      if (fire_i && pend_idx_o == IW'(i)) state_d[i] = ENT_ISSUED;
      if (s2_live && s2_idx_i == IW'(i)) begin
        if (s2_nack_i) begin
          retry_d[i] = retry_inc;
          if (s2_exhaust_o) state_d[i] = exhaust_report_i ? ENT_FREE : ENT_ERR;
          else              state_d[i] = ENT_PEND;
        end else if (cmd_q[i] == M_XWR) begin
          state_d[i] = ENT_WDONE;
        end
      end
      if (rsp_done_i && rsp_idx_i == IW'(i)) state_d[i] = ENT_FREE;
      if (rel_valid_i && rel_idx_i == IW'(i)) state_d[i] = ENT_FREE;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (reset) begin
        state_q[i] <= ENT_FREE;
        retry_q[i] <= '0;
      end else begin
        state_q[i] <= state_d[i];
        retry_q[i] <= retry_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_i) begin
      cmd_q[free_idx_o]  <= alloc_cmd_i;
      typ_q[free_idx_o]  <= alloc_typ_i;
      addr_q[free_idx_o] <= alloc_addr_i;
      data_q[free_idx_o] <= alloc_data_i;
      mask_q[free_idx_o] <= alloc_mask_i;
    end
  end

endmodule

// File: rtl/hella_cache_master_engine.sv
// Multi-outstanding dmem master: command accept, s1/s2 request pipeline,
// nack replay and single-port completion arbitration.
module hella_cache_master_engine
  import hella_cache_pkg::*;
#(
  parameter int unsigned NUM_ADDR_BITS   = 40,
  parameter int unsigned NUM_DATA_BITS   = 64,
  parameter int unsigned NUM_TAG_BITS    = 7,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [4:0]                            cmd_cmd,
  input  logic [2:0]                            cmd_typ,
  input  logic [NUM_ADDR_BITS-1:0]              cmd_addr,
  input  logic [NUM_DATA_BITS-1:0]              cmd_data,
  input  logic [NUM_DATA_BITS/8-1:0]            cmd_mask,
  output logic [NUM_TAG_BITS-1:0]               cmd_tag,
  input  logic                                  req_ready,
  output logic                                  req_valid,
  output logic [NUM_ADDR_BITS-1:0]              req_addr,
  output logic [NUM_TAG_BITS-1:0]               req_tag,
  output logic [4:0]                            req_cmd,
  output logic [2:0]                            req_typ,
  output logic [NUM_DATA_BITS-1:0]              req_data,
  output logic [NUM_DATA_BITS/8-1:0]            req_data_mask,
  output logic                                  req_kill,
  input  logic                                  rsp_valid,
  input  logic                                  rsp_nack,
  input  logic [NUM_TAG_BITS-1:0]               rsp_tag,
  input  logic [NUM_DATA_BITS-1:0]              rsp_data,
  output logic                                  cpl_valid,
  output logic [NUM_TAG_BITS-1:0]               cpl_tag,
  output logic [NUM_DATA_BITS-1:0]              cpl_data,
  output logic                                  cpl_err,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
  output logic                                  err_unexp_rsp
);

  localparam int unsigned IW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic                       free_any, pend_any, err_any, wdone_any;
  logic [IW-1:0]              free_idx, pend_idx, err_idx, wdone_idx;
  logic [4:0]                 pend_cmd;
  logic [2:0]                 pend_typ;
  logic [NUM_ADDR_BITS-1:0]   pend_addr;
  logic [NUM_DATA_BITS-1:0]   s1_data;
  logic [NUM_DATA_BITS/8-1:0] s1_mask;
  logic                       s2_nack_live, s2_exhaust, rsp_issued_rd;
  logic [CW-1:0]              outstanding_cnt;
  logic                       accept, fire, rsp_in_range, rsp_hit;
  logic [IW-1:0]              rsp_idx;
  logic                       rel_valid;
  logic [IW-1:0]              rel_idx;

  logic          s1_valid_q, s2_valid_q;
  logic [IW-1:0] s1_idx_q, s2_idx_q;
  logic          err_q;

  assign cmd_ready = free_any && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_tag   = reset ? '0 : NUM_TAG_BITS'(free_idx);

  assign req_valid     = pend_any && !reset;
  assign fire          = req_valid && req_ready;
  assign req_addr      = req_valid ? pend_addr : '0;
  assign req_tag       = req_valid ? NUM_TAG_BITS'(pend_idx) : '0;
  assign req_cmd       = req_valid ? pend_cmd : '0;
  assign req_typ       = req_valid ? pend_typ : '0;
  assign req_data      = (s1_valid_q && !reset) ? s1_data : '0;
  assign req_data_mask = (s1_valid_q && !reset) ? s1_mask : '0;
  assign req_kill      = 1'b0;

  // A nack and a response for the same tag in one cycle: the nack wins.
  assign rsp_in_range = 32'(rsp_tag) < 32'(MAX_OUTSTANDING);
  assign rsp_idx      = rsp_tag[IW-1:0];
  assign rsp_hit      = rsp_valid && rsp_in_range && rsp_issued_rd &&
                        !(s2_nack_live && (s2_idx_q == rsp_idx));

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s2_idx_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= fire;
      s1_idx_q   <= pend_idx;
      s2_valid_q <= s1_valid_q;
      s2_idx_q   <= s1_idx_q;
      if (rsp_valid && !rsp_hit) err_q <= 1'b1;
    end
  end

  // A blocked exhaustion parks its entry in ERR; it then outranks write-done.
  always_comb begin
    cpl_valid = 1'b0;
    cpl_tag   = '0;
    cpl_data  = '0;
    cpl_err   = 1'b0;
    rel_valid = 1'b0;
    rel_idx   = '0;
    if (!reset) begin
      if (rsp_hit) begin
        cpl_valid = 1'b1;
        cpl_tag   = NUM_TAG_BITS'(rsp_idx);
        cpl_data  = rsp_data;
      end else if (s2_exhaust) begin
        cpl_valid = 1'b1;
        cpl_tag   = NUM_TAG_BITS'(s2_idx_q);
        cpl_err   = 1'b1;
      end else if (err_any) begin
        cpl_valid = 1'b1;
        cpl_tag   = NUM_TAG_BITS'(err_idx);
        cpl_err   = 1'b1;
        rel_valid = 1'b1;
        rel_idx   = err_idx;
      end else if (wdone_any) begin
        cpl_valid = 1'b1;
        cpl_tag   = NUM_TAG_BITS'(wdone_idx);
        rel_valid = 1'b1;
        rel_idx   = wdone_idx;
      end
    end
  end

  assign outstanding   = reset ? '0 : outstanding_cnt;
  assign err_unexp_rsp = err_q && !reset;

  hella_cache_tag_table #(
    .NUM_ADDR_BITS   (NUM_ADDR_BITS),
    .NUM_DATA_BITS   (NUM_DATA_BITS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .MAX_RETRY       (MAX_RETRY)
  ) u_table (
    .clock            (clock),
    .reset            (reset),
    .alloc_i          (accept),
    .alloc_cmd_i      (cmd_cmd),
    .alloc_typ_i      (cmd_typ),
    .alloc_addr_i     (cmd_addr),
    .alloc_data_i     (cmd_data),
    .alloc_mask_i     (cmd_mask),
    .free_any_o       (free_any),
    .free_idx_o       (free_idx),
    .pend_any_o       (pend_any),
    .pend_idx_o       (pend_idx),
    .pend_cmd_o       (pend_cmd),
    .pend_typ_o       (pend_typ),
    .pend_addr_o      (pend_addr),
    .fire_i           (fire),
    .s1_idx_i         (s1_idx_q),
    .s1_data_o        (s1_data),
    .s1_mask_o        (s1_mask),
    .s2_valid_i       (s2_valid_q),
    .s2_idx_i         (s2_idx_q),
    .s2_nack_i        (rsp_nack),
    .s2_nack_live_o   (s2_nack_live),
    .s2_exhaust_o     (s2_exhaust),
    .exhaust_report_i (!rsp_hit),
    .rsp_idx_i        (rsp_idx),
    .rsp_issued_rd_o  (rsp_issued_rd),
    .rsp_done_i       (rsp_hit),
    .rel_valid_i      (rel_valid),
    .rel_idx_i        (rel_idx),
    .err_any_o        (err_any),
    .err_idx_o        (err_idx),
    .wdone_any_o      (wdone_any),
    .wdone_idx_o      (wdone_idx),
    .outstanding_o    (outstanding_cnt)
  );

endmodule

// File: tb/tb_hella_cache_master_engine.sv
// Directed bench for hella_cache_master_engine with hand-computed expectations.
module tb_hella_cache_master_engine;
  import hella_cache_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_cmd;
  logic [2:0]  cmd_typ;
  logic [39:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [7:0]  cmd_mask;
  logic [6:0]  cmd_tag;
  logic        req_ready, req_valid;
  logic [39:0] req_addr;
  logic [6:0]  req_tag;
  logic [4:0]  req_cmd;
  logic [2:0]  req_typ;
  logic [63:0] req_data;
  logic [7:0]  req_data_mask;
  logic        req_kill;
  logic        rsp_valid, rsp_nack;
  logic [6:0]  rsp_tag;
  logic [63:0] rsp_data;
  logic        cpl_valid;
  logic [6:0]  cpl_tag;
  logic [63:0] cpl_data;
  logic        cpl_err;
  logic [2:0]  outstanding;
  logic        err_unexp_rsp;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  hella_cache_master_engine #(
    .NUM_ADDR_BITS   (40),
    .NUM_DATA_BITS   (64),
    .NUM_TAG_BITS    (7),
    .MAX_OUTSTANDING (4),
    .MAX_RETRY       (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_cmd       (cmd_cmd),
    .cmd_typ       (cmd_typ),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .cmd_mask      (cmd_mask),
    .cmd_tag       (cmd_tag),
    .req_ready     (req_ready),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_tag       (req_tag),
    .req_cmd       (req_cmd),
    .req_typ       (req_typ),
    .req_data      (req_data),
    .req_data_mask (req_data_mask),
    .req_kill      (req_kill),
    .rsp_valid     (rsp_valid),
    .rsp_nack      (rsp_nack),
    .rsp_tag       (rsp_tag),
    .rsp_data      (rsp_data),
    .cpl_valid     (cpl_valid),
    .cpl_tag       (cpl_tag),
    .cpl_data      (cpl_data),
    .cpl_err       (cpl_err),
    .outstanding   (outstanding),
    .err_unexp_rsp (err_unexp_rsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic set_cmd(input logic [4:0] c, input logic [39:0] a,
                         input logic [63:0] d, input logic [7:0] m);
    cmd_valid = 1'b1;
    cmd_cmd   = c;
    cmd_typ   = 3'd3;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
  endtask

  initial begin
    logic [6:0]  rsp_order [4];
    logic [63:0] rsp_vals  [4];
    rsp_order[0] = 7'd2; rsp_order[1] = 7'd0; rsp_order[2] = 7'd3; rsp_order[3] = 7'd1;
    rsp_vals[0]  = 64'h22; rsp_vals[1] = 64'h100; rsp_vals[2] = 64'h33; rsp_vals[3] = 64'h11;

    reset = 1'b1; cmd_valid = 1'b0; cmd_cmd = '0; cmd_typ = '0; cmd_addr = '0;
    cmd_data = '0; cmd_mask = '0; req_ready = 1'b0; rsp_valid = 1'b0;
    rsp_nack = 1'b0; rsp_tag = '0; rsp_data = '0;

    // Reset
    next_cyc();
    settle();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    next_cyc();
    reset = 1'b0;
    settle();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_cpl_valid", 64'(cpl_valid), 64'd0);
    chk("idle_err_unexp", 64'(err_unexp_rsp), 64'd0);
    chk("idle_req_kill", 64'(req_kill), 64'd0);
    next_cyc();

    // Single load: accept, fire next cycle, response four cycles after fire
    set_cmd(M_XRD, 40'h1000, 64'd0, 8'd0);
    req_ready = 1'b1;
    settle();
    chk("ld_cmd_tag", 64'(cmd_tag), 64'd0);
    chk("ld_no_early_req", 64'(req_valid), 64'd0);
    next_cyc();
    cmd_valid = 1'b0;
    settle();
    chk("ld_req_valid", 64'(req_valid), 64'd1);
    chk("ld_req_addr", 64'(req_addr), 64'h1000);
    chk("ld_req_tag", 64'(req_tag), 64'd0);
    chk("ld_req_cmd", 64'(req_cmd), 64'd0);
    chk("ld_outstanding1", 64'(outstanding), 64'd1);
    next_cyc();
    settle();
    chk("ld_req_idle", 64'(req_valid), 64'd0);
    next_cyc();
    settle();
    chk("ld_s2_no_cpl", 64'(cpl_valid), 64'd0);
    next_cyc();
    next_cyc();
    rsp_valid = 1'b1; rsp_tag = 7'd0; rsp_data = 64'hDEADBEEF;
    settle();
    chk("ld_cpl_valid", 64'(cpl_valid), 64'd1);
    chk("ld_cpl_tag", 64'(cpl_tag), 64'd0);
    chk("ld_cpl_data", cpl_data, 64'hDEADBEEF);
    chk("ld_cpl_err", 64'(cpl_err), 64'd0);
    next_cyc();
    rsp_valid = 1'b0;
    settle();
    chk("ld_outstanding0", 64'(outstanding), 64'd0);
    chk("ld_cpl_once", 64'(cpl_valid), 64'd0);
    next_cyc();

    // Store: s1 data one cycle after fire, completion three cycles after fire
    set_cmd(M_XWR, 40'h2000, 64'h55AA, 8'h03);
    settle();
    chk("st_cmd_tag", 64'(cmd_tag), 64'd0);
    next_cyc();
    cmd_valid = 1'b0;
    settle();
    chk("st_req_valid", 64'(req_valid), 64'd1);
    chk("st_req_cmd", 64'(req_cmd), 64'd1);
    chk("st_data_before_s1", req_data, 64'd0);
    next_cyc();
    settle();
    chk("st_req_data", req_data, 64'h55AA);
    chk("st_req_mask", 64'(req_data_mask), 64'h03);
    next_cyc();
    settle();
    chk("st_s2_no_cpl", 64'(cpl_valid), 64'd0);
    next_cyc();
    settle();
    chk("st_cpl_valid", 64'(cpl_valid), 64'd1);
    chk("st_cpl_tag", 64'(cpl_tag), 64'd0);
    chk("st_cpl_data", cpl_data, 64'd0);
    chk("st_cpl_err", 64'(cpl_err), 64'd0);
    next_cyc();
    settle();
    chk("st_outstanding0", 64'(outstanding), 64'd0);
    chk("st_data_after", req_data, 64'd0);
    next_cyc();

    // Load nacked twice, third attempt succeeds
    set_cmd(M_XRD, 40'h3000, 64'd0, 8'd0);
    next_cyc();
    cmd_valid = 1'b0;
    settle();
    chk("nk2_fire1", 64'(req_valid), 64'd1);
    next_cyc();
    next_cyc();
    rsp_nack = 1'b1;
    settle();
    chk("nk2_nack1_no_cpl", 64'(cpl_valid), 64'd0);
    next_cyc();
    rsp_nack = 1'b0;
    settle();
    chk("nk2_fire2", 64'(req_valid), 64'd1);
    chk("nk2_fire2_tag", 64'(req_tag), 64'd0);
    next_cyc();
    next_cyc();
    rsp_nack = 1'b1;
    next_cyc();
    rsp_nack = 1'b0;
    settle();
    chk("nk2_fire3", 64'(req_valid), 64'd1);
    next_cyc();
    next_cyc();
    settle();
    chk("nk2_s2_ok_no_cpl", 64'(cpl_valid), 64'd0);
    chk("nk2_no_fire4", 64'(req_valid), 64'd0);
    next_cyc();
    rsp_valid = 1'b1; rsp_tag = 7'd0; rsp_data = 64'h1234;
    settle();
    chk("nk2_cpl_valid", 64'(cpl_valid), 64'd1);
    chk("nk2_cpl_data", cpl_data, 64'h1234);
    chk("nk2_cpl_err", 64'(cpl_err), 64'd0);
    next_cyc();
    rsp_valid = 1'b0;
    settle();
    chk("nk2_outstanding0", 64'(outstanding), 64'd0);
    next_cyc();

    // Load nacked three times: error completion on the third nack
    set_cmd(M_XRD, 40'h3800, 64'd0, 8'd0);
    next_cyc();
    cmd_valid = 1'b0;
    next_cyc();
    next_cyc();
    rsp_nack = 1'b1;
    next_cyc();
    rsp_nack = 1'b0;
    next_cyc();
    next_cyc();
    rsp_nack = 1'b1;
    next_cyc();
    rsp_nack = 1'b0;
    settle();
    chk("nk3_fire3", 64'(req_valid), 64'd1);
    next_cyc();
    next_cyc();
    rsp_nack = 1'b1;
    settle();
    chk("nk3_cpl_valid", 64'(cpl_valid), 64'd1);
    chk("nk3_cpl_err", 64'(cpl_err), 64'd1);
    chk("nk3_cpl_tag", 64'(cpl_tag), 64'd0);
    chk("nk3_cpl_data", cpl_data, 64'd0);
    next_cyc();
    rsp_nack = 1'b0;
    settle();
    chk("nk3_no_replay", 64'(req_valid), 64'd0);
    chk("nk3_outstanding0", 64'(outstanding), 64'd0);
    chk("nk3_cpl_once", 64'(cpl_valid), 64'd0);
    next_cyc();

    // Four loads held back, then answered out of order
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(M_XRD, 40'h4000 + 40'(i * 8), 64'd0, 8'd0);
      settle();
      chk("ooo_cmd_tag", 64'(cmd_tag), 64'(i));
      next_cyc();
    end
    cmd_valid = 1'b0;
    req_ready = 1'b1;
    settle();
    chk("ooo_cmd_ready_full", 64'(cmd_ready), 64'd0);
    chk("ooo_outstanding4", 64'(outstanding), 64'd4);
    chk("ooo_fire_tag0", 64'(req_tag), 64'd0);
    next_cyc();
    settle();
    chk("ooo_fire_tag1", 64'(req_tag), 64'd1);
    next_cyc();
    next_cyc();
    next_cyc();
    req_ready = 1'b0;
    settle();
    chk("ooo_all_fired", 64'(req_valid), 64'd0);
    next_cyc();
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1; rsp_tag = rsp_order[i]; rsp_data = rsp_vals[i];
      settle();
      chk("ooo_cpl_valid", 64'(cpl_valid), 64'd1);
      chk("ooo_cpl_tag", 64'(cpl_tag), 64'(rsp_order[i]));
      chk("ooo_cpl_data", cpl_data, rsp_vals[i]);
      next_cyc();
    end
    rsp_valid = 1'b0;
    settle();
    chk("ooo_outstanding0", 64'(outstanding), 64'd0);
    chk("ooo_no_unexp", 64'(err_unexp_rsp), 64'd0);
    next_cyc();

    // Response completion and store s2 clearance in the same cycle
    req_ready = 1'b1;
    set_cmd(M_XWR, 40'h5000, 64'hA5, 8'h01);
    settle();
    chk("same_st_tag", 64'(cmd_tag), 64'd0);
    next_cyc();
    set_cmd(M_XRD, 40'h6000, 64'd0, 8'd0);
    settle();
    chk("same_ld_tag", 64'(cmd_tag), 64'd1);
    chk("same_st_fire", 64'(req_tag), 64'd0);
    next_cyc();
    cmd_valid = 1'b0;
    settle();
    chk("same_ld_fire", 64'(req_tag), 64'd1);
    chk("same_st_s1_data", req_data, 64'hA5);
    next_cyc();
    rsp_valid = 1'b1; rsp_tag = 7'd1; rsp_data = 64'hBEEF;
    settle();
    chk("same_rsp_first_tag", 64'(cpl_tag), 64'd1);
    chk("same_rsp_first_data", cpl_data, 64'hBEEF);
    next_cyc();
    rsp_valid = 1'b0;
    settle();
    chk("same_st_second_valid", 64'(cpl_valid), 64'd1);
    chk("same_st_second_tag", 64'(cpl_tag), 64'd0);
    chk("same_st_second_data", cpl_data, 64'd0);
    next_cyc();
    rsp_valid = 1'b1; rsp_tag = 7'd0; rsp_data = 64'd0;
    settle();
    chk("unexp_no_cpl", 64'(cpl_valid), 64'd0);
    chk("unexp_not_yet", 64'(err_unexp_rsp), 64'd0);
    next_cyc();
    rsp_valid = 1'b0;
    settle();
    chk("unexp_sticky", 64'(err_unexp_rsp), 64'd1);
    chk("unexp_outstanding0", 64'(outstanding), 64'd0);
    next_cyc();

    // Reset with a load in flight; its late response is unexpected
    set_cmd(M_XRD, 40'h7000, 64'd0, 8'd0);
    next_cyc();
    cmd_valid = 1'b0;
    next_cyc();
    reset = 1'b1;
    settle();
    chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    next_cyc();
    reset = 1'b0;
    rsp_valid = 1'b1; rsp_tag = 7'd0; rsp_data = 64'h77;
    settle();
    chk("mid_rst_err_clear", 64'(err_unexp_rsp), 64'd0);
    chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
    chk("mid_rst_no_cpl", 64'(cpl_valid), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    next_cyc();
    rsp_valid = 1'b0;
    settle();
    chk("mid_rst_late_rsp", 64'(err_unexp_rsp), 64'd1);
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
